// File: rtl/wb_arbiter_if.sv
// Bundle of the write-back arbiter's signals: ALU and LSU result handshakes plus the register-file write port.
// The arbiter connects through the slave modport; result producers use the master modport.
interface wb_arbiter_if #(
  parameter int XLEN = 32,
  parameter int RW   = 5
);
  logic            alu_valid;
  logic            alu_ready;
  logic [XLEN-1:0] alu_data;
  logic [RW-1:0]   alu_rd;

  logic            lsu_valid;
  logic            lsu_ready;
  logic [XLEN-1:0] lsu_data;
  logic [RW-1:0]   lsu_rd;

  logic            rf_we;
  logic [RW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            busy;

  modport slave (
    input  alu_valid, alu_data, alu_rd,
    input  lsu_valid, lsu_data, lsu_rd,
    output alu_ready, lsu_ready,
    output rf_we, rf_waddr, rf_wdata, busy
  );

  modport master (
    output alu_valid, alu_data, alu_rd,
    output lsu_valid, lsu_data, lsu_rd,
    input  alu_ready, lsu_ready,
    input  rf_we, rf_waddr, rf_wdata, busy
  );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: one QDEPTH-entry FIFO per result source, one register-file write per cycle.
// Define WB_RR_ARB_EN for round-robin arbitration; the default is fixed priority, LSU over ALU.
module wb_arbiter #(
  parameter int QDEPTH = 2,
  parameter int XLEN   = 32,
  parameter int RW     = 5
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);
  typedef logic [RW-1:0] rs_addr_t;
  typedef struct packed {
    logic [XLEN-1:0] data;
    rs_addr_t        rd;
  } entry_t;

  localparam int PW  = $clog2(QDEPTH);
  localparam int CW  = $clog2(QDEPTH + 1);
  localparam int ALU = 0;
  localparam int LSU = 1;

  entry_t          mem   [2][QDEPTH];
  logic [PW-1:0]   wptr  [2];
  logic [PW-1:0]   rptr  [2];
  logic [CW-1:0]   count [2];
  entry_t          in_entry [2];
  entry_t          head     [2];
  logic [1:0]      in_valid, ready, push, pop, nonempty;
  logic            grant_alu, grant_lsu;
  logic            rf_we_q;
  rs_addr_t        rf_waddr_q;
  logic [XLEN-1:0] rf_wdata_q;

  always_comb begin
    in_valid      = {bus.lsu_valid, bus.alu_valid};
    in_entry[ALU] = '{data: bus.alu_data, rd: bus.alu_rd};
    in_entry[LSU] = '{data: bus.lsu_data, rd: bus.lsu_rd};
    for (int s = 0; s < 2; s++) begin
      nonempty[s] = (count[s] != '0);
      ready[s]    = rst && (count[s] != CW'(QDEPTH));
      // A handshake targeting x0 completes but is dropped here.
      push[s]     = in_valid[s] && ready[s] && (in_entry[s].rd != '0);
      head[s]     = mem[s][rptr[s]];
    end
  end

`ifdef WB_RR_ARB_EN
  logic last_alu;

  // NOTE: every always_comb output gets an unconditional value first, so no path can infer a latch.
  always_comb begin
    grant_lsu = 1'b0;
    grant_alu = 1'b0;
    if (nonempty[LSU] && (!nonempty[ALU] || last_alu)) grant_lsu = 1'b1;
    else if (nonempty[ALU])                             grant_alu = 1'b1;
  end

  // Reset value favours LSU on the first contended cycle; only a grant moves the pointer.
  always_ff @(posedge clk) begin
    if (!rst)                        last_alu <= 1'b1;
    else if (grant_lsu || grant_alu) last_alu <= grant_alu;
  end
`else
  // NOTE: every always_comb output gets an unconditional value first, so no path can infer a latch.
  always_comb begin
    grant_lsu = nonempty[LSU];
    grant_alu = nonempty[ALU] && !nonempty[LSU];
  end
`endif

  assign pop = {grant_lsu, grant_alu};

  // NOTE: non-blocking assignments make every register sample pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < 2; s++) begin
        wptr[s]  <= '0;
        rptr[s]  <= '0;
        count[s] <= '0;
      end
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) wptr[s] <= wptr[s] + PW'(1);
        if (pop[s])  rptr[s] <= rptr[s] + PW'(1);
        count[s] <= count[s] + CW'(push[s]) - CW'(pop[s]);
      end
      rf_we_q <= grant_lsu || grant_alu;
      if (grant_lsu) begin
        rf_waddr_q <= head[LSU].rd;
        rf_wdata_q <= head[LSU].data;
      end else if (grant_alu) begin
        rf_waddr_q <= head[ALU].rd;
        rf_wdata_q <= head[ALU].data;
      end
    end
  end

  // NOTE: queue storage is deliberately not reset; the occupancy counters alone decide which entries are live.
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) mem[s][wptr[s]] <= in_entry[s];
    end
  end

  assign bus.alu_ready = ready[ALU];
  assign bus.lsu_ready = ready[LSU];
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.busy      = (nonempty != 2'b00) || rf_we_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios then random traffic, all checked against a queue-based model.
// Works with or without WB_RR_ARB_EN defined.
module tb_wb_arbiter;
  localparam int QDEPTH = 2;
  localparam int XLEN   = 32;
  localparam int RW     = 5;
`ifdef WB_RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic [XLEN-1:0] data;
    logic [RW-1:0]   rd;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  wb_arbiter_if #(.XLEN(XLEN), .RW(RW)) bus ();
  wb_arbiter #(.QDEPTH(QDEPTH), .XLEN(XLEN), .RW(RW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: pending results per source, the last write, and who was served last.
  item_t           aq[$];
  item_t           lq[$];
  bit              m_we;
  logic [RW-1:0]   m_waddr;
  logic [XLEN-1:0] m_wdata;
  bit              m_last_alu;
  bit              known = 1'b0;
  bit              alu_acc, lsu_acc;
  logic [RW-1:0]   wlog[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_alu(input bit v, input int rd, input logic [XLEN-1:0] d);
    bus.alu_valid = v;
    bus.alu_rd    = RW'(rd);
    bus.alu_data  = d;
  endtask

  task automatic set_lsu(input bit v, input int rd, input logic [XLEN-1:0] d);
    bus.lsu_valid = v;
    bus.lsu_rd    = RW'(rd);
    bus.lsu_data  = d;
  endtask

  task automatic idle();
    set_alu(1'b0, 0, '0);
    set_lsu(1'b0, 0, '0);
  endtask

  // One clock: check pre-edge outputs, advance the model, check registered outputs after the edge.
  task automatic cycle();
    bit    has_a, has_l, gl, ga;
    item_t it;
    #1;
    check("alu_ready", bus.alu_ready, rst && (aq.size() < QDEPTH));
    check("lsu_ready", bus.lsu_ready, rst && (lq.size() < QDEPTH));
    if (known) check("busy", bus.busy, (aq.size() != 0) || (lq.size() != 0) || m_we);
    alu_acc = 1'b0;
    lsu_acc = 1'b0;
    if (!rst) begin
      aq.delete();
      lq.delete();
      m_we       = 1'b0;
      m_waddr    = '0;
      m_wdata    = '0;
      m_last_alu = 1'b1;
      known      = 1'b1;
    end else begin
      alu_acc = bus.alu_valid && (aq.size() < QDEPTH);
      lsu_acc = bus.lsu_valid && (lq.size() < QDEPTH);
      has_a = (aq.size() != 0);
      has_l = (lq.size() != 0);
      gl = has_l && (!RR || !has_a || m_last_alu);
      ga = has_a && !gl;
      m_we = gl || ga;
      if (gl) begin
        it = lq.pop_front();
        m_waddr = it.rd; m_wdata = it.data; m_last_alu = 1'b0;
      end else if (ga) begin
        it = aq.pop_front();
        m_waddr = it.rd; m_wdata = it.data; m_last_alu = 1'b1;
      end
      if (alu_acc && bus.alu_rd != '0) begin
        it.data = bus.alu_data; it.rd = bus.alu_rd;
        aq.push_back(it);
      end
      if (lsu_acc && bus.lsu_rd != '0) begin
        it.data = bus.lsu_data; it.rd = bus.lsu_rd;
        lq.push_back(it);
      end
    end
    @(posedge clk);
    #1;
    check("rf_we", bus.rf_we, m_we);
    check("rf_waddr", bus.rf_waddr, m_waddr);
    check("rf_wdata", bus.rf_wdata, m_wdata);
    if (bus.rf_we === 1'b1) wlog.push_back(bus.rf_waddr);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    cycle();
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit            got;
    logic [RW-1:0] seen[$];
    int            hits;

    idle();
    rst = 1'b0;
    @(negedge clk);
    cycle();
    cycle();
    check("reset_busy", bus.busy, 0);
    check("reset_rf_we", bus.rf_we, 0);
    check("reset_waddr", bus.rf_waddr, 0);

    // Single uncontended ALU result: write two edges after it is offered.
    rst = 1'b1;
    set_alu(1'b1, 5, 32'h11);
    cycle();
    check("single_edge1_we", bus.rf_we, 0);
    idle();
    cycle();
    check("single_we", bus.rf_we, 1);
    check("single_waddr", bus.rf_waddr, 5);
    check("single_wdata", bus.rf_wdata, 32'h11);
    cycle();
    check("single_we_after", bus.rf_we, 0);
    check("single_busy_after", bus.busy, 0);

    // Simultaneous offers from reset: LSU writes first in both arbitration modes.
    do_reset();
    set_alu(1'b1, 3, 32'hA);
    set_lsu(1'b1, 4, 32'hB);
    cycle();
    idle();
    cycle();
    check("both_first_waddr", bus.rf_waddr, 4);
    check("both_first_wdata", bus.rf_wdata, 32'hB);
    cycle();
    check("both_second_waddr", bus.rf_waddr, 3);
    check("both_second_wdata", bus.rf_wdata, 32'hA);
    cycle();
    check("both_busy_after", bus.busy, 0);

    // Both sources continuously valid: alternate under round-robin, LSU only under fixed priority.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      set_alu(1'b1, 10, XLEN'(k));
      set_lsu(1'b1, 20, XLEN'(100 + k));
      cycle();
      if (k >= 1) begin
        check("contend_we", bus.rf_we, 1);
        check("contend_order", bus.rf_waddr, (!RR || (k % 2 == 1)) ? 20 : 10);
      end
    end
    idle();
    repeat (8) cycle();
    check("contend_drained", bus.busy, 0);

    // ALU queue fills while the LSU saturates the port; third item waits for the first ALU pop.
    do_reset();
    wlog.delete();
    set_alu(1'b1, 7, 32'h70); set_lsu(1'b1, 21, 32'h0);
    cycle();
    set_alu(1'b1, 8, 32'h80); set_lsu(1'b1, 21, 32'h1);
    cycle();
    set_alu(1'b1, 9, 32'h90); set_lsu(1'b1, 21, 32'h2);
    #1;
    check("full_alu_ready_low", bus.alu_ready, 0);
    cycle();
    set_lsu(1'b0, 0, '0);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      cycle();
      got = alu_acc;
    end
    check("full_third_accepted", got, 1);
    idle();
    repeat (6) cycle();
    foreach (wlog[i]) if (wlog[i] inside {5'd7, 5'd8, 5'd9}) seen.push_back(wlog[i]);
    check("order_count", seen.size(), 3);
    for (int i = 0; i < seen.size() && i < 3; i++) check("order_rd", seen[i], 7 + i);

    // Handshake to x0 completes but never produces a write.
    do_reset();
    set_alu(1'b1, 0, 32'hFF);
    #1;
    check("rd0_ready", bus.alu_ready, 1);
    cycle();
    check("rd0_busy", bus.busy, 0);
    idle();
    cycle();
    check("rd0_no_we", bus.rf_we, 0);

    // Reset with two entries queued discards both.
    do_reset();
    wlog.delete();
    set_alu(1'b1, 12, 32'hC);
    set_lsu(1'b1, 13, 32'hD);
    cycle();
    idle();
    rst = 1'b0;
    cycle();
    check("midrst_we", bus.rf_we, 0);
    check("midrst_busy", bus.busy, 0);
    rst = 1'b1;
    repeat (4) cycle();
    hits = 0;
    foreach (wlog[i]) if (wlog[i] inside {5'd12, 5'd13}) hits++;
    check("midrst_discarded", hits, 0);

    // Random traffic, including x0 targets and occasional resets.
    do_reset();
    repeat (400) begin
      rst = ($urandom_range(0, 49) != 0);
      set_alu(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), XLEN'($urandom));
      set_lsu(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), XLEN'($urandom));
      cycle();
    end
    rst = 1'b1;
    idle();
    repeat (8) cycle();
    check("random_drained", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter QDEPTH, default 2, per-source queue depth (power of two, >=2).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous active-low reset.
REQ-004 SHALL have port alu_valid  input  1  ALU result offered.
REQ-005 SHALL have port alu_ready  output  1  ALU result accepted when alu_valid&&alu_ready at edge.
REQ-006 SHALL have port alu_data  input  XLEN  ALU result value.
REQ-007 SHALL have port alu_rd  input  rs_addr_t  ALU destination register.
REQ-008 SHALL have ports lsu_valid/lsu_ready/lsu_data/lsu_rd with the same direction, width and meaning for LSU load results.
REQ-009 SHALL have port rf_we  output  1  register-file write enable (registered).
REQ-010 SHALL have port rf_waddr  output  rs_addr_t  write address (registered).
REQ-011 SHALL have port rf_wdata  output  XLEN  write data (registered).
REQ-012 SHALL have port busy  output  1  high while any queue is non-empty or rf_we is high.

Function
REQ-013 SHALL hold one FIFO of QDEPTH entries {data, rd} per source, each with an occupancy counter 0..QDEPTH.
REQ-014 SHALL drive src_ready = !full for that source; no full-queue bypass.
REQ-015 SHALL accept a handshake with rd==0 without enqueuing it; no rf write ever targets x0.
REQ-016 SHALL grant at most one non-empty queue head per cycle and pop it at the next edge.
REQ-017 SHALL, at the edge that pops a head, load rf_we=1, rf_waddr=head.rd, rf_wdata=head.data; with no grant, rf_we=0 and rf_waddr/rf_wdata hold.
REQ-018 SHALL give latency of exactly 2 edges from acceptance to rf_we high when uncontended.
REQ-019 SHALL allow push and pop of the same queue in one cycle; the occupancy counter is unchanged.
REQ-020 SHALL wrap read/write pointers modulo QDEPTH.
REQ-021 SHALL keep per-source order (FIFO); no ordering guarantee between sources.
REQ-022 SHALL compute busy combinationally from occupancy and rf_we.

Reset
REQ-023 SHALL, while rst==0 at an edge: empty both queues, pointers=0, rf_we=0, rf_waddr=0, rf_wdata=0, round-robin pointer set to favour LSU.
REQ-024 SHALL drive alu_ready=lsu_ready=0 while rst==0.
REQ-025 SHALL discard queued entries on reset mid-operation; no rf write issues in the cycle after reset deasserts.

Configuration
REQ-026 SHALL, with WB_RR_ARB_EN defined: arbitrate round-robin; the source not granted last wins when both heads are valid; the pointer updates only on a grant.
REQ-027 SHALL, without WB_RR_ARB_EN: arbitrate fixed priority, LSU over ALU; ALU is granted only when the LSU queue is empty.

Verification
REQ-028 SHALL cover: release reset; alu_valid, alu_rd=5, alu_data=0x11 for one cycle -> rf_we=1, rf_waddr=5, rf_wdata=0x11 exactly 2 edges later, busy low afterwards.
REQ-029 SHALL cover: same cycle, ALU (rd=3,0xA) and LSU (rd=4,0xB) -> LSU write first, ALU write the next cycle (both configurations, from reset).
REQ-030 SHALL cover: WB_RR_ARB_EN, both sources continuously valid -> grants alternate L,A,L,A; without macro -> only LSU is granted while LSU stays valid.
REQ-031 SHALL cover: QDEPTH=2, ALU valid 3 cycles with no drain (LSU saturating) -> alu_ready low on 3rd cycle, third item accepted after the first pop, order preserved.
REQ-032 SHALL cover: alu_rd=0, data 0xFF accepted -> no rf_we, occupancy stays 0.
REQ-033 SHALL cover: two entries queued, rst low one cycle -> rf_we=0, busy=0, no queued entry ever written.
